sram_bus_arbiter: RTL and testbench
===================================

// Module: sram_bus_arbiter
// PURPOSE
//  Shares the single SRAM-like CPU bus between instruction fetch and the MEM stage, one transaction at a time.
//  Sits between the IF/MEM stages and the SRAM-to-AXI bridge.
//  Latches the granted request, sequences the bus handshake and returns read data with a done pulse.
//  Raises stall_o until every pending requester has been served.
// PARAMETERS
//  DATA_FIRST  1  1: data beats inst when both request in IDLE; 0: inst first
// PORTS
//  clk_i          in   1   clock, rising edge
//  reset_i        in   1   asynchronous reset, active-high
//  inst_req_i     in   1   fetch request; level, held until inst_done_o
//  inst_addr_i    in   32  fetch address, word aligned
//  inst_rdata_o   out  32  fetched word, valid while inst_done_o
//  inst_done_o    out  1   1-cycle completion pulse
//  data_req_i     in   1   MEM request (ram_read_enable | ram_write_enable); level
//  data_wr_i      in   1   1 = write, 0 = read
//  data_wsel_i    in   4   byte write select (0001..1000, 0011, 1100, 1111)
//  data_addr_i    in   32  word-aligned address
//  data_wdata_i   in   32  byte-replicated write data
//  data_rdata_o   out  32  read word, valid while data_done_o
//  data_done_o    out  1   1-cycle completion pulse
//  flush_i        in   1   exception flush: drop any inst result
//  stall_o        out  1   freeze pipeline
//  bus_req_o      out  1   SRAM-like request
//  bus_wr_o       out  1   write
//  bus_size_o     out  2   0 = byte, 1 = half, 2 = word
//  bus_addr_o     out  32  byte address
//  bus_wdata_o    out  32  write data
//  bus_addr_ok_i  in   1   request accepted
//  bus_data_ok_i  in   1   data returned / write done
//  bus_rdata_i    in   32  read data
// BEHAVIOUR
//  Reset:
//  - All outputs 0, state IDLE, served flags 0, discard 0.
//  - Reset mid-transaction drops it at once: bus_req_o goes 0 asynchronously. The bridge shares reset_i.
//  FSM IDLE -> ADDR -> DATA -> DONE -> IDLE:
//  - IDLE: pick a requester with req_i=1 and served=0, priority per DATA_FIRST. Latch wr/size/addr/wdata and owner; go ADDR.
//  - ADDR: bus_req_o=1 with latched fields held stable. On addr_ok go DATA. A request is never withdrawn once bus_req_o=1.
//  - DATA: bus_req_o=0. On data_ok register bus_rdata_i into the owner's rdata, set the owner's served flag, go DONE.
//  - DONE: owner's done_o=1 for exactly this cycle; go IDLE.
//  - No arbitration in ADDR/DATA/DONE.
//  Latency: req in IDLE at cycle 0, addr_ok in 1st ADDR cycle, data_ok in 1st DATA cycle -> done_o at cycle 3. Each bus wait cycle adds 1.
//  Field mapping:
//  - Reads: size 2, addr = data_addr_i or inst_addr_i as given.
//  - Writes: size and low address bits come from wsel.
//    0001/0010/0100/1000 -> size 0, addr[1:0] = 0/1/2/3.
//    0011/1100 -> size 1, addr[1:0] = 0/2.
//    1111 -> size 2, addr[1:0] = 0.
//  - Illegal wsel is never granted: done pulse without a bus cycle, rdata 0.
//  stall_o = (inst_req_i & ~inst_served) | (data_req_i & ~data_served), combinational.
//  - Served flags clear in any cycle where stall_o=0, i.e. the pipeline advances.
//  - A requester that holds req high while the other is served is never re-issued.
//  Flush:
//  - flush_i in ADDR/DATA with owner=inst sets discard. The bus handshake still completes.
//  - In DONE: inst_done_o suppressed, inst_served set.
//  - flush_i in IDLE with inst pending: the inst request is not granted that cycle.
//  - Data transactions ignore flush_i. MEM has already gated writes on exceptions.
//  Simultaneous addr_ok and data_ok in ADDR: take both, go directly to DONE.
// STRUCTURE
//  - bus_defs.vh: state encodings, SIZE_BYTE/HALF/WORD, owner encoding, wsel->size/offset function.
//  - Single flat module; no sub-module is warranted.
// TESTING
//  1. Data LW, addr 0x8000_0010, addr_ok/data_ok immediate, rdata 0x1234_5678 -> data_done_o and data_rdata_o=0x1234_5678 at cycle 3; stall_o 1 for cycles 0-2.
//  2. SB wsel=0100, addr 0x8000_0020, wdata 0xABABABAB -> bus_addr_o=0x8000_0022, size 0, bus_wr_o=1.
//  3. inst and data request same cycle, DATA_FIRST=1 -> data served first; inst served next, not data twice; stall_o drops after inst_done_o.
//  4. addr_ok delayed 3 cycles -> bus_req_o and fields held stable for all 4 cycles.
//  5. flush_i during inst DATA -> bus completes, inst_done_o never pulses, next IDLE grants a new request.
//  6. reset_i asserted in ADDR -> bus_req_o=0 without a clock edge; after release state IDLE, all outputs 0.

Source files
------------

// File: rtl/sram_bus_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// sram_bus_arbiter_pkg
//   Shared definitions for the SRAM-like bus arbiter: FSM state encoding,
//   transaction owner encoding, bus size codes and the byte-write-select
//   decoder that turns a wsel pattern into a bus size and a low address offset.
// ---------------------------------------------------------------------------
package sram_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_t;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef struct packed {
        logic       legal;
        logic [1:0] size;
        logic [1:0] offset;
    } wsel_map_t;

    // Only naturally aligned byte, halfword and word patterns are legal.
    function automatic wsel_map_t wsel_decode(input logic [3:0] wsel);
        wsel_map_t m;
        m.legal  = 1'b1;
        m.size   = SIZE_BYTE;
        m.offset = 2'd0;
        case (wsel)
            4'b0001: m.offset = 2'd0;
            4'b0010: m.offset = 2'd1;
            4'b0100: m.offset = 2'd2;
            4'b1000: m.offset = 2'd3;
            4'b0011: begin
                m.size   = SIZE_HALF;
                m.offset = 2'd0;
            end
            4'b1100: begin
                m.size   = SIZE_HALF;
                m.offset = 2'd2;
            end
            4'b1111: begin
                m.size   = SIZE_WORD;
                m.offset = 2'd0;
            end
            default: m.legal = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/sram_bus_arbiter.sv
// ---------------------------------------------------------------------------
// sram_bus_arbiter
//   Shares one SRAM-like bus between instruction fetch and the MEM stage, one
//   transaction at a time. The granted request is latched, the bus handshake
//   is sequenced and read data is returned with a one-cycle done pulse.
//   stall_o holds the pipeline until every pending requester has been served.
//
//   State | meaning
//   IDLE  | arbitrate between unserved requesters
//   ADDR  | bus_req_o high with latched fields, waiting for addr_ok
//   DATA  | waiting for data_ok
//   DONE  | owner's done pulse (inst pulse suppressed if flushed)
//
// Ports
//   clk_i, reset_i                  clock, async active-high reset
//   inst_req_i/addr_i               fetch request (level) and address
//   inst_rdata_o/done_o             fetched word and completion pulse
//   data_req_i/wr_i/wsel_i          MEM request, direction, byte select
//   data_addr_i/wdata_i             MEM address and write data
//   data_rdata_o/done_o             MEM read word and completion pulse
//   flush_i                         exception flush, drops inst result
//   stall_o                         pipeline freeze (combinational)
//   bus_req_o/wr_o/size_o/addr_o/wdata_o   SRAM-like request side
//   bus_addr_ok_i/data_ok_i/rdata_i        SRAM-like response side
// ---------------------------------------------------------------------------
module sram_bus_arbiter
    import sram_bus_arbiter_pkg::*;
#(
    parameter bit DATA_FIRST = 1'b1
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        inst_req_i,
    input  logic [31:0] inst_addr_i,
    output logic [31:0] inst_rdata_o,
    output logic        inst_done_o,
    input  logic        data_req_i,
    input  logic        data_wr_i,
    input  logic [3:0]  data_wsel_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic [31:0] data_rdata_o,
    output logic        data_done_o,
    input  logic        flush_i,
    output logic        stall_o,
    output logic        bus_req_o,
    output logic        bus_wr_o,
    output logic [1:0]  bus_size_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_addr_ok_i,
    input  logic        bus_data_ok_i,
    input  logic [31:0] bus_rdata_i
);

    state_t      r_state;
    owner_t      r_owner;
    logic        r_bus_req;
    logic        r_bus_wr;
    logic [1:0]  r_bus_size;
    logic [31:0] r_bus_addr;
    logic [31:0] r_bus_wdata;
    logic [31:0] r_inst_rdata;
    logic [31:0] r_data_rdata;
    logic        r_inst_done;
    logic        r_data_done;
    logic        r_inst_served;
    logic        r_data_served;
    logic        r_discard;

    logic        w_inst_pending;
    logic        w_data_pending;
    logic        w_inst_eligible;
    logic        w_pick_data;
    logic        w_pick_inst;
    logic        w_complete;
    logic        w_drop_inst;
    wsel_map_t   w_wmap;

    assign w_inst_pending  = inst_req_i & ~r_inst_served;
    assign w_data_pending  = data_req_i & ~r_data_served;
    // A flush in IDLE means the fetch address is stale; hold off granting it.
    assign w_inst_eligible = w_inst_pending & ~flush_i;
    assign w_pick_data     = w_data_pending & (DATA_FIRST | ~w_inst_eligible);
    assign w_pick_inst     = w_inst_eligible & ~w_pick_data;
    assign w_wmap          = wsel_decode(data_wsel_i);

    // addr_ok and data_ok together in ADDR finish the transaction at once.
    assign w_complete  = ((r_state == ST_ADDR) & bus_addr_ok_i & bus_data_ok_i) |
                         ((r_state == ST_DATA) & bus_data_ok_i);
    assign w_drop_inst = r_discard | flush_i;

    assign stall_o = w_inst_pending | w_data_pending;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state       <= ST_IDLE;
            r_owner       <= OWN_INST;
            r_bus_req     <= 1'b0;
            r_bus_wr      <= 1'b0;
            r_bus_size    <= SIZE_BYTE;
            r_bus_addr    <= '0;
            r_bus_wdata   <= '0;
            r_inst_rdata  <= '0;
            r_data_rdata  <= '0;
            r_inst_done   <= 1'b0;
            r_data_done   <= 1'b0;
            r_inst_served <= 1'b0;
            r_data_served <= 1'b0;
            r_discard     <= 1'b0;
        end else begin
            r_inst_done <= 1'b0;
            r_data_done <= 1'b0;

            // Pipeline advances whenever stall is low, so served history resets.
            if (!stall_o) begin
                r_inst_served <= 1'b0;
                r_data_served <= 1'b0;
            end

            if (((r_state == ST_ADDR) || (r_state == ST_DATA)) &&
                (r_owner == OWN_INST) && flush_i) begin
                r_discard <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_pick_data) begin
                        r_owner <= OWN_DATA;
                        if (data_wr_i && !w_wmap.legal) begin
                            // Malformed write: complete without touching the bus.
                            r_data_rdata  <= '0;
                            r_data_done   <= 1'b1;
                            r_data_served <= 1'b1;
                            r_state       <= ST_DONE;
                        end else begin
                            r_bus_req   <= 1'b1;
                            r_bus_wr    <= data_wr_i;
                            r_bus_size  <= data_wr_i ? w_wmap.size : SIZE_WORD;
                            r_bus_addr  <= data_wr_i ? {data_addr_i[31:2], w_wmap.offset}
                                                     : data_addr_i;
                            r_bus_wdata <= data_wdata_i;
                            r_state     <= ST_ADDR;
                        end
                    end else if (w_pick_inst) begin
                        r_owner     <= OWN_INST;
                        r_bus_req   <= 1'b1;
                        r_bus_wr    <= 1'b0;
                        r_bus_size  <= SIZE_WORD;
                        r_bus_addr  <= inst_addr_i;
                        r_bus_wdata <= '0;
                        r_state     <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (bus_addr_ok_i) begin
                        r_bus_req <= 1'b0;
                        r_state   <= bus_data_ok_i ? ST_DONE : ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (bus_data_ok_i) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state   <= ST_IDLE;
                    r_discard <= 1'b0;
                end
                default: r_state <= ST_IDLE;
            endcase

            if (w_complete) begin
                if (r_owner == OWN_DATA) begin
                    r_data_rdata  <= bus_rdata_i;
                    r_data_done   <= 1'b1;
                    r_data_served <= 1'b1;
                end else begin
                    // A flushed fetch still counts as served so stall can drop.
                    r_inst_rdata  <= bus_rdata_i;
                    r_inst_done   <= ~w_drop_inst;
                    r_inst_served <= 1'b1;
                end
            end
        end
    end

    assign inst_rdata_o = r_inst_rdata;
    assign inst_done_o  = r_inst_done;
    assign data_rdata_o = r_data_rdata;
    assign data_done_o  = r_data_done;
    assign bus_req_o    = r_bus_req;
    assign bus_wr_o     = r_bus_wr;
    assign bus_size_o   = r_bus_size;
    assign bus_addr_o   = r_bus_addr;
    assign bus_wdata_o  = r_bus_wdata;

endmodule

// File: tb/tb_sram_bus_arbiter.sv
module tb_sram_bus_arbiter;

    logic        clk_i;
    logic        reset_i;
    logic        inst_req_i;
    logic [31:0] inst_addr_i;
    logic [31:0] inst_rdata_o;
    logic        inst_done_o;
    logic        data_req_i;
    logic        data_wr_i;
    logic [3:0]  data_wsel_i;
    logic [31:0] data_addr_i;
    logic [31:0] data_wdata_i;
    logic [31:0] data_rdata_o;
    logic        data_done_o;
    logic        flush_i;
    logic        stall_o;
    logic        bus_req_o;
    logic        bus_wr_o;
    logic [1:0]  bus_size_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic        bus_addr_ok_i;
    logic        bus_data_ok_i;
    logic [31:0] bus_rdata_i;

    sram_bus_arbiter #(.DATA_FIRST(1'b1)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .inst_req_i(inst_req_i), .inst_addr_i(inst_addr_i),
        .inst_rdata_o(inst_rdata_o), .inst_done_o(inst_done_o),
        .data_req_i(data_req_i), .data_wr_i(data_wr_i), .data_wsel_i(data_wsel_i),
        .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
        .data_rdata_o(data_rdata_o), .data_done_o(data_done_o),
        .flush_i(flush_i), .stall_o(stall_o),
        .bus_req_o(bus_req_o), .bus_wr_o(bus_wr_o), .bus_size_o(bus_size_o),
        .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
        .bus_addr_ok_i(bus_addr_ok_i), .bus_data_ok_i(bus_data_ok_i),
        .bus_rdata_i(bus_rdata_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } bus_exp_t;

    typedef struct {
        bit          is_data;
        logic [31:0] rdata;
    } done_exp_t;

    bus_exp_t    exp_bus_q[$];
    done_exp_t   done_q[$];
    logic [31:0] rsp_q[$];

    int n_checks = 0;
    int n_errors = 0;
    int cfg_addr_wait = 0;
    int cfg_data_wait = 0;
    bit cfg_combined  = 1'b0;

    task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic push_bus(input logic wr, input logic [1:0] size,
                            input logic [31:0] addr, input logic [31:0] wdata);
        bus_exp_t e;
        e.wr = wr; e.size = size; e.addr = addr; e.wdata = wdata;
        exp_bus_q.push_back(e);
    endtask

    task automatic push_done(input bit is_data, input logic [31:0] rdata);
        done_exp_t e;
        e.is_data = is_data; e.rdata = rdata;
        done_q.push_back(e);
    endtask

    function automatic logic [31:0] next_rsp();
        if (rsp_q.size() > 0) return rsp_q.pop_front();
        return 32'h0;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Bus model: answers requests with configurable wait states and checks the
    // request fields against the expected transaction every cycle they are up.
    initial begin
        int aw_cnt;
        int dw_cnt;
        bit in_data;
        aw_cnt = 0; dw_cnt = 0; in_data = 1'b0;
        bus_addr_ok_i = 1'b0; bus_data_ok_i = 1'b0; bus_rdata_i = '0;
        forever begin
            @(negedge clk_i);
            bus_addr_ok_i = 1'b0;
            bus_data_ok_i = 1'b0;
            if (reset_i) begin
                aw_cnt = 0; dw_cnt = 0; in_data = 1'b0;
            end else if (in_data) begin
                if (dw_cnt == 0) begin
                    bus_data_ok_i = 1'b1;
                    bus_rdata_i   = next_rsp();
                    in_data       = 1'b0;
                end else begin
                    dw_cnt--;
                end
            end else if (bus_req_o) begin
                chk("bus_req_expected", exp_bus_q.size() != 0, 1);
                if (exp_bus_q.size() != 0)
                    chk("bus_fields", {bus_wr_o, bus_size_o, bus_addr_o, bus_wdata_o},
                        {exp_bus_q[0].wr, exp_bus_q[0].size, exp_bus_q[0].addr,
                         exp_bus_q[0].wdata});
                if (aw_cnt < cfg_addr_wait) begin
                    aw_cnt++;
                end else begin
                    bus_addr_ok_i = 1'b1;
                    aw_cnt = 0;
                    if (exp_bus_q.size() != 0) void'(exp_bus_q.pop_front());
                    if (cfg_combined) begin
                        bus_data_ok_i = 1'b1;
                        bus_rdata_i   = next_rsp();
                    end else begin
                        in_data = 1'b1;
                        dw_cnt  = cfg_data_wait;
                    end
                end
            end
        end
    end

    // Completion monitor: every done pulse must match the next queued result.
    initial begin
        done_exp_t e;
        forever begin
            @(negedge clk_i);
            if (!reset_i && (inst_done_o || data_done_o)) begin
                chk("done_single", inst_done_o & data_done_o, 0);
                chk("done_expected", done_q.size() != 0, 1);
                if (done_q.size() != 0) begin
                    e = done_q.pop_front();
                    chk("done_kind", data_done_o, e.is_data);
                    chk("done_rdata", data_done_o ? data_rdata_o : inst_rdata_o, e.rdata);
                end
            end
        end
    end

    task automatic wait_done(input bit is_data, input int budget,
                             output int lat, output int stall_hi);
        bit seen;
        seen = 1'b0; lat = 0; stall_hi = 0;
        while (!seen && lat < budget) begin
            tick();
            lat++;
            seen = is_data ? data_done_o : inst_done_o;
            if (!seen && stall_o) stall_hi++;
        end
        chk(is_data ? "data_done_seen" : "inst_done_seen", seen, 1);
    endtask

    task automatic data_txn(input string nm, input bit wr, input logic [3:0] wsel,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] rsp, input logic [31:0] exp_addr,
                            input logic [1:0] exp_size, input bit legal, input int exp_lat);
        int lat;
        int shi;
        if (legal) begin
            push_bus(wr, exp_size, exp_addr, wdata);
            rsp_q.push_back(rsp);
        end
        push_done(1'b1, legal ? rsp : 32'h0);
        data_wr_i = wr; data_wsel_i = wsel; data_addr_i = addr; data_wdata_i = wdata;
        data_req_i = 1'b1;
        #1 chk({nm, "_stall_c0"}, stall_o, 1);
        wait_done(1'b1, 30, lat, shi);
        chk({nm, "_latency"}, lat, exp_lat);
        chk({nm, "_stall_before_done"}, shi, lat - 1);
        chk({nm, "_stall_at_done"}, stall_o, 0);
        data_req_i = 1'b0;
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        int shi;
        reset_i = 1'b1;
        inst_req_i = 1'b0; inst_addr_i = '0;
        data_req_i = 1'b0; data_wr_i = 1'b0; data_wsel_i = '0;
        data_addr_i = '0; data_wdata_i = '0; flush_i = 1'b0;
        repeat (3) tick();
        chk("rst_bus_req", bus_req_o, 0);
        chk("rst_bus_fields", {bus_wr_o, bus_size_o, bus_addr_o, bus_wdata_o}, 0);
        chk("rst_done", {inst_done_o, data_done_o, stall_o}, 0);
        chk("rst_rdata", {inst_rdata_o, data_rdata_o}, 0);
        reset_i = 1'b0;
        tick();

        // word read, no bus waits; wsel ignored for reads
        data_txn("lw", 1'b0, 4'b0000, 32'h8000_0010, 32'h0, 32'h1234_5678,
                 32'h8000_0010, 2'd2, 1'b1, 3);
        // writes: size and low address bits from wsel
        data_txn("sb2", 1'b1, 4'b0100, 32'h8000_0020, 32'hABAB_ABAB, 32'h0,
                 32'h8000_0022, 2'd0, 1'b1, 3);
        data_txn("sb3", 1'b1, 4'b1000, 32'h8000_0024, 32'hCDCD_CDCD, 32'h0,
                 32'h8000_0027, 2'd0, 1'b1, 3);
        data_txn("sb0", 1'b1, 4'b0001, 32'h8000_0028, 32'h5A5A_5A5A, 32'h0,
                 32'h8000_0028, 2'd0, 1'b1, 3);
        data_txn("sh2", 1'b1, 4'b1100, 32'h8000_0030, 32'h1234_1234, 32'h0,
                 32'h8000_0032, 2'd1, 1'b1, 3);
        data_txn("sw", 1'b1, 4'b1111, 32'h8000_0034, 32'hCAFE_F00D, 32'h0000_0001,
                 32'h8000_0034, 2'd2, 1'b1, 3);
        // illegal byte select: immediate done, no bus cycle, rdata 0
        data_txn("bad_wsel", 1'b1, 4'b0101, 32'h8000_0038, 32'h7777_7777, 32'hFFFF_FFFF,
                 32'h0, 2'd0, 1'b0, 1);

        // addr_ok delayed 3 cycles: fields held for 4 request cycles
        cfg_addr_wait = 3;
        data_txn("lw_wait", 1'b0, 4'b0000, 32'h8000_0040, 32'h0, 32'h0BAD_CAFE,
                 32'h8000_0040, 2'd2, 1'b1, 6);
        cfg_addr_wait = 0;

        // addr_ok and data_ok together
        cfg_combined = 1'b1;
        data_txn("lw_comb", 1'b0, 4'b0000, 32'h8000_0044, 32'h0, 32'h5555_AAAA,
                 32'h8000_0044, 2'd2, 1'b1, 2);
        cfg_combined = 1'b0;

        // both request: data first, then inst once, then stall drops
        push_bus(1'b0, 2'd2, 32'h8000_0050, 32'h0);
        push_bus(1'b0, 2'd2, 32'hBFC0_0000, 32'h0);
        rsp_q.push_back(32'h1111_1111);
        rsp_q.push_back(32'h2222_2222);
        push_done(1'b1, 32'h1111_1111);
        push_done(1'b0, 32'h2222_2222);
        data_wr_i = 1'b0; data_addr_i = 32'h8000_0050; data_wdata_i = 32'h0;
        data_req_i = 1'b1;
        inst_addr_i = 32'hBFC0_0000; inst_req_i = 1'b1;
        wait_done(1'b1, 30, lat, shi);
        chk("both_data_lat", lat, 3);
        chk("both_stall_after_data", stall_o, 1);
        wait_done(1'b0, 30, lat, shi);
        chk("both_inst_lat", lat, 4);
        chk("both_stall_after_inst", stall_o, 0);
        data_req_i = 1'b0; inst_req_i = 1'b0;
        repeat (4) tick();

        // flush while inst request pending in IDLE delays its grant one cycle
        push_bus(1'b0, 2'd2, 32'hBFC0_0010, 32'h0);
        rsp_q.push_back(32'h6666_6666);
        push_done(1'b0, 32'h6666_6666);
        inst_addr_i = 32'hBFC0_0010; inst_req_i = 1'b1; flush_i = 1'b1;
        tick();
        chk("flush_idle_no_grant", bus_req_o, 0);
        flush_i = 1'b0;
        wait_done(1'b0, 30, lat, shi);
        chk("flush_idle_lat", lat, 3);
        inst_req_i = 1'b0;
        tick();

        // flush during inst DATA: bus completes, no inst_done, next fetch granted
        cfg_data_wait = 2;
        push_bus(1'b0, 2'd2, 32'hBFC0_0100, 32'h0);
        rsp_q.push_back(32'h3333_3333);
        inst_addr_i = 32'hBFC0_0100; inst_req_i = 1'b1;
        tick();
        chk("flush_addr_req", bus_req_o, 1);
        tick();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        chk("flush_no_done_c3", inst_done_o, 0);
        tick();
        chk("flush_no_done_c4", inst_done_o, 0);
        tick();
        chk("flush_no_done_c5", inst_done_o, 0);
        chk("flush_stall_c5", stall_o, 0);
        cfg_data_wait = 0;
        push_bus(1'b0, 2'd2, 32'hBFC0_0380, 32'h0);
        rsp_q.push_back(32'h4444_4444);
        push_done(1'b0, 32'h4444_4444);
        inst_addr_i = 32'hBFC0_0380;
        wait_done(1'b0, 30, lat, shi);
        chk("flush_next_lat", lat, 4);
        inst_req_i = 1'b0;
        tick();

        // reset in ADDR drops bus_req_o without a clock edge
        cfg_addr_wait = 5;
        push_bus(1'b0, 2'd2, 32'h8000_0060, 32'h0);
        data_wr_i = 1'b0; data_addr_i = 32'h8000_0060; data_req_i = 1'b1;
        tick();
        chk("rst_mid_req_up", bus_req_o, 1);
        #2 reset_i = 1'b1;
        #1 chk("rst_mid_req_async", bus_req_o, 0);
        data_req_i = 1'b0;
        exp_bus_q.delete();
        cfg_addr_wait = 0;
        repeat (2) tick();
        reset_i = 1'b0;
        tick();
        chk("rst_mid_bus", {bus_req_o, bus_wr_o, bus_size_o, bus_addr_o, bus_wdata_o}, 0);
        chk("rst_mid_out", {inst_done_o, data_done_o, stall_o, inst_rdata_o, data_rdata_o}, 0);
        data_txn("lw_after_rst", 1'b0, 4'b0000, 32'h8000_0070, 32'h0, 32'h8765_4321,
                 32'h8000_0070, 2'd2, 1'b1, 3);

        repeat (4) tick();
        chk("bus_q_drained", exp_bus_q.size(), 0);
        chk("done_q_drained", done_q.size(), 0);
        chk("rsp_q_drained", rsp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
